// File: rtl/sao_pkg.sv
// SAO shared types and constants.
// Used by the apply path and the statistics block.
package sao_pkg;

    localparam int SAMPLE_W = 8;
    localparam int BAND_SPAN = 4;

    typedef logic [SAMPLE_W-1:0] sample_t;
    typedef logic signed [SAMPLE_W+1:0] sign_sample_t;

    typedef enum logic [1:0] {
        SAO_OFF  = 2'd0,
        SAO_BAND = 2'd1,
        SAO_EDGE = 2'd2,
        SAO_RSVD = 2'd3
    } sao_type_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } sao_state_e;

    localparam logic [1:0] EO_VALLEY  = 2'd0;
    localparam logic [1:0] EO_CONCAVE = 2'd1;
    localparam logic [1:0] EO_CONVEX  = 2'd2;
    localparam logic [1:0] EO_PEAK    = 2'd3;

    function automatic logic signed [2:0] sgn3(
        input logic gt,
        input logic lt
    );
        return gt ? 3'sd1 : (lt ? -3'sd1 : 3'sd0);
    endfunction

endpackage

// File: rtl/sao_apply_one_block_if.sv
// Parameter, block-in and block-out handshakes
// of the SAO apply block.
interface sao_apply_one_block_if #(
    parameter int bit_depth = 8,
    parameter int off_bit   = 5
);
    logic                               par_valid;
    logic                               par_ready;
    logic [1:0]                         par_type;
    logic [3:0][off_bit-1:0]            par_offset;
    logic [4:0]                         par_band_pos;
    logic                               in_valid;
    logic                               in_ready;
    logic [3:0][3:0][bit_depth-1:0]     rec_m;
    logic [3:0][bit_depth-1:0]          rec_l;
    logic [3:0][bit_depth-1:0]          rec_r;
    logic                               out_valid;
    logic                               out_ready;
    logic [3:0][3:0][bit_depth-1:0]     out_m;
    logic                               out_last;

    modport master (
        output par_valid, par_type, par_offset, par_band_pos,
        output in_valid, rec_m, rec_l, rec_r, out_ready,
        input  par_ready, in_ready, out_valid, out_m, out_last
    );

    modport slave (
        input  par_valid, par_type, par_offset, par_band_pos,
        input  in_valid, rec_m, rec_l, rec_r, out_ready,
        output par_ready, in_ready, out_valid, out_m, out_last
    );
endinterface

// File: rtl/sao_classify_sample.sv
// Per-sample SAO category: whether an offset applies
// and which of the four offsets it is.
module sao_classify_sample
    import sao_pkg::*;
#(
    parameter int bit_depth = 8
) (
    input  sao_type_e            typ,
    input  logic [4:0]           band_pos,
    input  logic [bit_depth-1:0] c,
    input  logic [bit_depth-1:0] l,
    input  logic [bit_depth-1:0] r,
    output logic                 hit,
    output logic [1:0]           idx
);
    logic signed [2:0] s;
    logic [4:0]        k;

    // Edge sum and band distance, then pick the offset slot.
    always_comb begin
        s   = sgn3(c > l, c < l) + sgn3(c > r, c < r);
        k   = c[bit_depth-1 -: 5] - band_pos;
        hit = 1'b0;
        idx = 2'd0;
        unique case (1'b1)
            (typ == SAO_BAND): begin
                hit = (k < 5'(BAND_SPAN));
                idx = k[1:0];
            end
            (typ == SAO_EDGE): begin
                unique case (s)
                    -3'sd2: begin hit = 1'b1; idx = EO_VALLEY;  end
                    -3'sd1: begin hit = 1'b1; idx = EO_CONCAVE; end
                     3'sd1: begin hit = 1'b1; idx = EO_CONVEX;  end
                     3'sd2: begin hit = 1'b1; idx = EO_PEAK;    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/sao_apply_one_block.sv
// SAO apply for one CTU of 4x4 blocks: classify stage,
// then offset add/clip stage, framed by a per-CTU FSM.
module sao_apply_one_block
    import sao_pkg::*;
#(
    parameter int bit_depth = 8,
    parameter int num_blk   = 256,
    parameter int off_bit   = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sao_apply_one_block_if.slave bus,
    output logic                 busy
);
    localparam logic signed [bit_depth+1:0] MAXV =
        {2'b00, {bit_depth{1'b1}}};

    sao_state_e              state_q, state_d;
    logic [10:0]             cnt_q;
    sao_type_e               typ_q;
    logic [3:0][off_bit-1:0] off_q;
    logic [4:0]              bpos_q;

    logic par_rdy, par_hs, in_hs, out_hs, in_last;
    logic s1_ready, s2_ready;

    logic                           s1_valid, s1_last;
    logic [3:0][3:0][bit_depth-1:0] s1_pix;
    logic [3:0][3:0]                s1_hit, cls_hit;
    logic [3:0][3:0][1:0]           s1_idx, cls_idx;

    logic                           out_valid_q, out_last_q;
    logic [3:0][3:0][bit_depth-1:0] out_m_q, res;
    logic signed [bit_depth+1:0]    sum;
    logic [off_bit-1:0]             off;

    assign s2_ready = !out_valid_q || bus.out_ready;
    assign s1_ready = !s1_valid || s2_ready;
    assign par_hs   = bus.par_valid && par_rdy;
    assign in_hs    = bus.in_valid && bus.in_ready;
    assign out_hs   = out_valid_q && bus.out_ready;
    assign in_last  = (cnt_q == 11'(num_blk - 1));

    assign bus.par_ready = par_rdy;
    assign bus.in_ready  = (state_q == ST_RUN) && s1_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_m     = out_m_q;
    assign busy          = (state_q != ST_IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state; parameters only accepted while idle.
    always_comb begin
        state_d = state_q;
        par_rdy = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                par_rdy = 1'b1;
                if (bus.par_valid) state_d = ST_RUN;
            end
            ST_RUN:
                if (in_hs && in_last) state_d = ST_DRAIN;
            ST_DRAIN:
                if (out_hs && out_last_q) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // CTU parameters and block counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            typ_q  <= SAO_OFF;
            off_q  <= '0;
            bpos_q <= '0;
            cnt_q  <= '0;
        end else if (par_hs) begin
            typ_q  <= sao_type_e'(bus.par_type);
            off_q  <= bus.par_offset;
            bpos_q <= bus.par_band_pos;
            cnt_q  <= '0;
        end else if (in_hs) begin
            cnt_q  <= cnt_q + 11'd1;
        end
    end

    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < 4; c++) begin : g_col
            logic [bit_depth-1:0] nl, nr;
            if (c == 0) begin : g_l0
                assign nl = bus.rec_l[r];
            end else begin : g_ln
                assign nl = bus.rec_m[r][c-1];
            end
            if (c == 3) begin : g_r3
                assign nr = bus.rec_r[r];
            end else begin : g_rn
                assign nr = bus.rec_m[r][c+1];
            end
            sao_classify_sample #(
                .bit_depth(bit_depth)
            ) u_cls (
                .typ      (typ_q),
                .band_pos (bpos_q),
                .c        (bus.rec_m[r][c]),
                .l        (nl),
                .r        (nr),
                .hit      (cls_hit[r][c]),
                .idx      (cls_idx[r][c])
            );
        end
    end

    // Stage 1: hold samples with their categories.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_pix   <= '0;
            s1_hit   <= '0;
            s1_idx   <= '0;
        end else if (s1_ready) begin
            s1_valid <= in_hs;
            if (in_hs) begin
                s1_last <= in_last;
                s1_pix  <= bus.rec_m;
                s1_hit  <= cls_hit;
                s1_idx  <= cls_idx;
            end
        end
    end

    // Offset add at bit_depth+2 bits, then clip to sample range.
    always_comb begin
        res = '0;
        sum = '0;
        off = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                off = off_q[s1_idx[r][c]];
                sum = $signed({2'b00, s1_pix[r][c]});
                if (s1_hit[r][c])
                    sum = sum + $signed({{(bit_depth+2-off_bit){off[off_bit-1]}}, off});
                if (sum < 0)         res[r][c] = '0;
                else if (sum > MAXV) res[r][c] = '1;
                else                 res[r][c] = sum[bit_depth-1:0];
            end
        end
    end

    // Stage 2: output register, frozen under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_m_q     <= '0;
        end else if (s2_ready) begin
            out_valid_q <= s1_valid;
            out_last_q  <= s1_valid && s1_last;
            if (s1_valid) out_m_q <= res;
        end
    end
endmodule
